// File: rtl/pwm_pkg.sv
// Shared audio constants used by the channel generators and the PWM output stage.
package pwm_pkg;
  localparam int AUDIO_SAMPLE_WIDTH = 9;
  localparam int PWM_PERIOD_DEFAULT = 511;
endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter: counts 0..PERIOD and flags the wrap cycle.
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int WIDTH  = AUDIO_SAMPLE_WIDTH,
  parameter int PERIOD = PWM_PERIOD_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD);

  assign o_wrap = (o_count == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_count <= '0;
    end else if (o_wrap) begin
      o_count <= '0;
    end else begin
      o_count <= o_count + WIDTH'(1);
    end
  end
endmodule

// File: rtl/pwm_dac_output.sv
// PWM output stage: double-buffered duty sample, glitch-free period-aligned
// updates, registered pin drive, period strobe and sticky underrun flag.
module pwm_dac_output
  import pwm_pkg::*;
#(
  parameter int WIDTH  = AUDIO_SAMPLE_WIDTH,
  parameter int PERIOD = PWM_PERIOD_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_sample,
  input  logic             i_sample_valid,
  output logic             o_sample_ready,
  input  logic             i_clear_underrun,
  output logic             o_pwm,
  output logic             o_period_start,
  output logic             o_underrun
);
  logic [WIDTH-1:0] r_count;
  logic             w_wrap;
  logic [WIDTH-1:0] r_active;
  logic [WIDTH-1:0] r_pending;
  logic             r_pending_full;
  logic             r_primed;
  logic             w_transfer;

  pwm_period_counter #(
    .WIDTH (WIDTH),
    .PERIOD(PERIOD)
  ) u_counter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_count(r_count),
    .o_wrap (w_wrap)
  );

  assign o_sample_ready = !r_pending_full;
  assign w_transfer     = i_sample_valid && !r_pending_full;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_active       <= '0;
      r_pending      <= '0;
      r_pending_full <= 1'b0;
      r_primed       <= 1'b0;
      o_pwm          <= 1'b0;
      o_period_start <= 1'b0;
      o_underrun     <= 1'b0;
    end else begin
      o_pwm          <= (r_count < r_active);
      o_period_start <= (r_count == '0);

      // A transfer can only land while pending is empty, so it never races the load.
      if (w_wrap && r_pending_full) begin
        r_active       <= r_pending;
        r_pending_full <= 1'b0;
        r_primed       <= 1'b1;
      end else if (w_transfer) begin
        r_pending      <= i_sample;
        r_pending_full <= 1'b1;
      end

      // Set has priority over a simultaneous clear.
      if (w_wrap && !r_pending_full && r_primed) begin
        o_underrun <= 1'b1;
      end else if (i_clear_underrun) begin
        o_underrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pwm_dac_output.sv
// Directed bench for pwm_dac_output with WIDTH=4, PERIOD=7 (8-clock periods).
module tb_pwm_dac_output;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sample;
  logic       valid;
  logic       clear;
  logic       ready;
  logic       pwm;
  logic       ps;
  logic       und;

  int n_checks = 0;
  int n_err    = 0;
  int acc_cnt  = 0;
  logic [3:0] q[$];

  typedef struct {
    logic [3:0] sample;
    logic [7:0] pat;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  pwm_dac_output #(
    .WIDTH (4),
    .PERIOD(7)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_sample        (sample),
    .i_sample_valid  (valid),
    .o_sample_ready  (ready),
    .i_clear_underrun(clear),
    .o_pwm           (pwm),
    .o_period_start  (ps),
    .o_underrun      (und)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    if (q.size() > 0) begin
      valid  = 1'b1;
      sample = q[0];
    end else begin
      valid  = 1'b0;
      sample = 4'd0;
    end
  endtask

  // Advance one clock (negedge to negedge), tracking accepted samples.
  task automatic step();
    logic x;
    x = valid && ready && !rst;
    @(negedge clk);
    if (x) begin
      if (q.size() > 0) void'(q.pop_front());
      acc_cnt++;
      check("ready_drop_after_xfer", 32'(ready), 0);
    end
    drive();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    clear = 1'b0;
    q.delete();
    drive();
    repeat (2) @(negedge clk);
    check("rst_pwm", 32'(pwm), 0);
    check("rst_ps", 32'(ps), 0);
    check("rst_und", 32'(und), 0);
    check("rst_ready", 32'(ready), 1);
  endtask

  task automatic release_reset();
    acc_cnt = 0;
    rst     = 1'b0;
    drive();
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!ps && n < 20) begin
      step();
      n++;
    end
    check("start_seen", 32'(ps), 1);
  endtask

  // Called on a period-start cycle; records one period of o_pwm / o_underrun.
  task automatic measure(input int clr_idx, output logic [7:0] pat, output logic [7:0] uv);
    logic mid;
    mid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == clr_idx) clear = 1'b1;
      pat[i] = pwm;
      uv[i]  = und;
      if (i > 0) mid = mid | ps;
      step();
      clear = 1'b0;
    end
    check("no_mid_strobe", 32'(mid), 0);
    check("period_len", 32'(ps), 1);
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] uv;
    vecs[0] = '{4'd3, 8'h07};
    vecs[1] = '{4'd3, 8'h07};
    vecs[2] = '{4'd0, 8'h00};
    vecs[3] = '{4'd8, 8'hFF};
    vecs[4] = '{4'd1, 8'h01};
    vecs[5] = '{4'd2, 8'h03};
    vecs[6] = '{4'd3, 8'h07};
    vecs[7] = '{4'd4, 8'h0F};
    rst    = 1'b1;
    valid  = 1'b0;
    sample = 4'd0;
    clear  = 1'b0;
    @(negedge clk);

    // Tests 1-3: continuous feed with back-pressure, duty boundaries included
    do_reset();
    for (int i = 0; i < 8; i++) q.push_back(vecs[i].sample);
    release_reset();
    check("ps_first_clock", 32'(ps), 0);
    step();
    check("accept_first_cycle", 32'(acc_cnt), 1);
    check("ps_second_clock", 32'(ps), 1);
    measure(-1, pat, uv);
    check("p0_idle_pat", 32'(pat), 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("acc_per_period[%0d]", i), 32'(acc_cnt), 32'((i + 2 > 8) ? 8 : i + 2));
      check($sformatf("no_underrun[%0d]", i), 32'(und), 0);
      measure(-1, pat, uv);
      check($sformatf("pat[%0d]", i), 32'(pat), 32'(vecs[i].pat));
    end

    // Test 4: underrun after loading 5; clear coinciding with a wrap loses
    do_reset();
    q.push_back(4'd5);
    release_reset();
    wait_start();
    measure(-1, pat, uv);
    check("u_p0_pat", 32'(pat), 0);
    check("u_p0_und", 32'(uv), 0);
    measure(-1, pat, uv);
    check("u_p1_pat", 32'(pat), 32'h1F);
    check("u_p1_und", 32'(uv), 32'h80);
    measure(6, pat, uv);
    check("u_p2_pat", 32'(pat), 32'h1F);
    check("u_p2_und_set_wins", 32'(uv), 32'hFF);
    measure(0, pat, uv);
    check("u_p3_pat", 32'(pat), 32'h1F);
    check("u_p3_und_clear_reset", 32'(uv), 32'h81);

    // Test 5: no samples ever -> never primed, no underrun
    do_reset();
    release_reset();
    wait_start();
    for (int i = 0; i < 3; i++) begin
      measure(-1, pat, uv);
      check($sformatf("unprimed_pat[%0d]", i), 32'(pat), 0);
      check($sformatf("unprimed_und[%0d]", i), 32'(uv), 0);
    end

    // Test 6: asynchronous reset mid-period with 6 active, 7 pending
    do_reset();
    q.push_back(4'd6);
    q.push_back(4'd7);
    release_reset();
    wait_start();
    measure(-1, pat, uv);
    check("r6_p0_pat", 32'(pat), 0);
    repeat (3) step();
    check("r6_mid_pwm_high", 32'(pwm), 1);
    check("r6_mid_pending_full", 32'(ready), 0);
    rst = 1'b1;
    q.delete();
    drive();
    #1;
    check("async_rst_pwm", 32'(pwm), 0);
    check("async_rst_ps", 32'(ps), 0);
    check("async_rst_und", 32'(und), 0);
    check("async_rst_ready", 32'(ready), 1);
    repeat (2) @(negedge clk);
    release_reset();
    wait_start();
    for (int i = 0; i < 2; i++) begin
      measure(-1, pat, uv);
      check($sformatf("post_rst_pat[%0d]", i), 32'(pat), 0);
      check($sformatf("post_rst_und[%0d]", i), 32'(uv), 0);
    end
    q.push_back(4'd2);
    drive();
    measure(-1, pat, uv);
    check("post_rst_load_pat0", 32'(pat), 0);
    measure(-1, pat, uv);
    check("post_rst_load_pat1", 32'(pat), 32'h03);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/pwm_dac_output.md
# pwm_dac_output

Downstream output stage for the audio channels: accepts a WIDTH-bit sample (the 9-bit compare value produced by a channel generator) over a valid/ready handshake and converts it to a single-bit PWM pin drive. A pending register double-buffers the sample so the active duty value changes only on a PWM period boundary, which keeps edges glitch-free. The block also reports period boundaries and sample underruns.

## Interface
- WIDTH, 9: sample / compare width.
- PERIOD, 511: counter maximum; one PWM period is PERIOD+1 clocks. PERIOD must be at most 2^WIDTH-1.
- i_clk  input  1  sole clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_sample  input  WIDTH  duty value; high time is i_sample clocks per period.
- i_sample_valid  input  1  i_sample is valid this cycle.
- o_sample_ready  output  1  pending buffer empty; a transfer occurs when valid && ready.
- i_clear_underrun  input  1  clears o_underrun.
- o_pwm  output  1  registered PWM drive.
- o_period_start  output  1  one-cycle strobe, aligned with the first o_pwm cycle of each period.
- o_underrun  output  1  sticky underrun flag.

## Operation
- r_count counts 0..PERIOD and wraps to 0. The wrap cycle is the cycle in which r_count == PERIOD.
- Pending buffer:
  - o_sample_ready = !r_pending_full. This is combinational from a register and does not depend on i_sample_valid.
  - On a transfer: r_pending <= i_sample and r_pending_full <= 1.
- Wrap cycle with pending full: r_active <= r_pending, r_pending_full <= 0, r_primed <= 1.
- Wrap cycle with pending empty: r_active holds its value. If r_primed is set, o_underrun <= 1.
- Transfer during a wrap cycle: only possible when pending is empty. The sample goes to pending and is not loaded until the next wrap, so underrun rules apply to this wrap.
- Underrun clear: i_clear_underrun clears o_underrun. If a set and a clear occur in the same cycle, the set wins.
- Outputs (both registered):
  - o_pwm <= (r_count < r_active), unsigned compare.
  - o_period_start <= (r_count == 0).
- Duty boundaries:
  - r_active = 0: o_pwm is constantly 0.
  - r_active >= PERIOD+1: o_pwm is constantly 1.
- Reset (asynchronous, immediate):
  - r_count = 0, r_active = 0, r_pending = 0, r_pending_full = 0, r_primed = 0.
  - o_pwm = 0, o_period_start = 0, o_underrun = 0.
  - o_sample_ready = 1.
- Reset mid-period or mid-transfer discards the pending and active samples. r_primed is cleared, so no underrun is reported before the first load.

## Timing
- After reset deasserts: r_count = 0 in the first clock, and o_period_start is high in the second clock.
- Sample latency, for a sample accepted in cycle t:
  - It is loaded at the first wrap cycle w ≥ t+1.
  - r_active takes the new value at w+1.
  - o_period_start and the first o_pwm cycle reflecting the new value both occur at w+2.
- o_pwm is high for exactly r_active consecutive cycles starting with the o_period_start cycle. It is then low for the remaining PERIOD+1-r_active cycles.
- Throughput: one sample per period. Ready deasserts from the cycle after a transfer until the cycle after the next wrap.
- o_underrun rises one cycle after the offending wrap cycle.

## Structure
- Shared package pwm_pkg holds AUDIO_SAMPLE_WIDTH = 9 and PWM_PERIOD_DEFAULT = 511. The channel generators and this block both use it.
- One natural sub-module is pwm_period_counter, parameterized by PERIOD. It outputs r_count and a wrap flag.
- The buffer, active register, compare, and flag logic live in pwm_dac_output.

## Test plan
1. Reset, WIDTH=4, PERIOD=7, then a single sample 3 with valid held high:
   - Sample accepted in the first cycle.
   - From the second o_period_start onward, o_pwm repeats the pattern 1,1,1,0,0,0,0,0.
   - o_underrun stays 0 while samples continue.
2. Samples 0 and 8, one per period:
   - o_pwm is all-0 for the period with 0.
   - o_pwm is all-1 for the period with 8.
   - Each period has exactly 8 cycles between o_period_start strobes.
3. Back-pressure: valid held high with sample values 1, 2, 3, 4.
   - o_sample_ready drops after each transfer.
   - Exactly one sample is accepted per period.
   - The high times observed are 1, 2, 3, 4 in order, with none skipped.
4. Underrun: load 5, then withhold valid for two periods.
   - o_pwm keeps a high time of 5.
   - o_underrun rises one cycle after the first empty wrap.
   - Pulsing i_clear_underrun on the same cycle as the second empty wrap leaves o_underrun at 1.
5. Startup with no samples: o_underrun stays 0 through 3 periods because the block is not yet primed.
6. Assert i_rst mid-period after loading 6 with 7 pending:
   - All outputs go to 0 immediately, and o_sample_ready goes to 1.
   - After release, o_pwm stays 0 until a new sample is loaded.
